// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction encoding constants and the fetch queue entry layout.
package pipeline_pkg;

  localparam int ADDR_WIDTH = 16;

  localparam logic [ADDR_WIDTH-1:0] INSTR_NOP = 16'h0000;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0] pc_pre;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue2.sv
// Two-entry FIFO of fetch entries with clear, push, pop; head entry and occupancy exposed.
module instr_queue2
  import pipeline_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_entry,
  output logic [1:0]   count
);

  fetch_entry_t entries [2];
  logic         head_ptr;
  logic         tail_ptr;
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         pop_ok;
  logic         push_ok;

  always_comb begin
    pop_ok     = pop && (count_reg != 2'd0);
    // A push into a full queue is only safe when the head slot is vacated the same cycle.
    push_ok    = push && ((count_reg != 2'd2) || pop_ok);
    tail_ptr   = head_ptr ^ count_reg[0];
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= 2'd0;
      head_ptr  <= 1'b0;
    end else if (clear) begin
      count_reg <= 2'd0;
      head_ptr  <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (pop_ok) begin
        head_ptr <= ~head_ptr;
      end
    end
  end

  // Storage needs no reset: contents are only observed when count is non-zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (reset && !clear && push_ok && (tail_ptr == 1'(gi))) begin
        entries[gi] <= push_entry;
      end
    end
  end

  assign head_entry = entries[head_ptr];
  assign count      = count_reg;

  no_push_when_full : assert property (
    @(posedge clock) disable iff (!reset)
    !(push && !clear && (count_reg == 2'd2))
  );

endmodule

// File: rtl/fetch_p2.sv
// Second fetch stage: tags the in-flight memory read, queues returned instructions for decode,
// and throttles the first fetch stage so the 2-entry queue never overflows.
module fetch_p2
  import pipeline_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] program_counter,
  input  logic [WIDTH-1:0] program_counter_pre,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             op_flush,
  input  logic             decode_ready,
  output logic             fetch_enable,
  output logic [WIDTH-1:0] ifid_instruction,
  output logic [WIDTH-1:0] ifid_pc_pre,
  output logic             ifid_valid,
  output logic [1:0]       queue_count
);

  logic             pend_valid;
  logic [WIDTH-1:0] pend_pc_pre;
  logic             push;
  logic             pop;
  logic [1:0]       count;
  logic [2:0]       occupancy_next;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign ifid_valid  = (count != 2'd0);
  assign queue_count = count;

  always_comb begin
    pop            = decode_ready & ifid_valid;
    push           = pend_valid & ~op_flush;
    occupancy_next = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    // Only issue a new read if its data will have room when it returns next cycle.
    fetch_enable   = reset & (op_flush | (occupancy_next <= 3'd1));
    push_entry.instruction = imem_rdata;
    push_entry.pc_pre      = pend_pc_pre;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_valid  <= 1'b0;
      pend_pc_pre <= '0;
    end else if (op_flush) begin
      pend_valid  <= 1'b0;
    end else begin
      pend_valid  <= fetch_enable;
      pend_pc_pre <= program_counter_pre;
    end
  end

  instr_queue2 u_queue (
    .clock      (clock),
    .reset      (reset),
    .clear      (op_flush),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (count)
  );

  assign ifid_instruction = ifid_valid ? head_entry.instruction : INSTR_NOP;
  assign ifid_pc_pre      = ifid_valid ? head_entry.pc_pre : '0;

  // The current address is consumed by the first fetch stage and memory, not here.
  logic unused_pc;
  assign unused_pc = ^program_counter;

endmodule

// File: tb/tb_fetch_p2.sv
// Scoreboard bench for fetch_p2: a PC/memory model drives the stage, a monitor checks every pop.
module tb_fetch_p2;
  import pipeline_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] program_counter;
  logic [15:0] program_counter_pre;
  logic [15:0] imem_rdata = 16'h0000;
  logic        op_flush = 1'b0;
  logic        decode_ready = 1'b0;
  logic        fetch_enable;
  logic [15:0] ifid_instruction;
  logic [15:0] ifid_pc_pre;
  logic        ifid_valid;
  logic [1:0]  queue_count;

  logic [15:0] pc_model = 16'h0000;
  logic [15:0] flush_target = 16'h0000;
  logic        pend_model = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;
  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          full_push_err = 0;
  bit          verbose = 1'b1;

  always #5 clock = ~clock;

  fetch_p2 #(.WIDTH(16)) dut (
    .clock               (clock),
    .reset               (reset),
    .program_counter     (program_counter),
    .program_counter_pre (program_counter_pre),
    .imem_rdata          (imem_rdata),
    .op_flush            (op_flush),
    .decode_ready        (decode_ready),
    .fetch_enable        (fetch_enable),
    .ifid_instruction    (ifid_instruction),
    .ifid_pc_pre         (ifid_pc_pre),
    .ifid_valid          (ifid_valid),
    .queue_count         (queue_count)
  );

  // First fetch stage and synchronous instruction memory returning 16'h1000 + addr.
  assign program_counter     = pc_model;
  assign program_counter_pre = pc_model + 16'd1;

  always @(posedge clock) begin
    if (!reset) pc_model <= 16'h0000;
    else if (op_flush) pc_model <= flush_target;
    else if (fetch_enable) pc_model <= pc_model + 16'd1;
    imem_rdata <= 16'h1000 + pc_model;
    if (!reset || op_flush) pend_model <= 1'b0;
    else pend_model <= fetch_enable;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic load_exp(logic [15:0] start, int n);
    logic [15:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = start + 16'(i);
      exp_q.push_back({16'h1000 + a, a + 16'd1});
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_count2(string name);
    int n;
    n = 0;
    while (queue_count != 2'd2 && n < 20) begin
      step();
      n++;
    end
    chk(name, 32'(n < 20), 32'd1);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'd0);
    chk({tag, "_instruction"}, 32'(ifid_instruction), 32'(INSTR_NOP));
    chk({tag, "_pc_pre"}, 32'(ifid_pc_pre), 32'd0);
    chk({tag, "_queue_count"}, 32'(queue_count), 32'd0);
    chk({tag, "_fetch_enable"}, 32'(fetch_enable), 32'd0);
  endtask

  // Monitor: every accepted pop must match the next expected entry of the PC sequence.
  always @(negedge clock) begin
    if (reset && pend_model && !op_flush && queue_count == 2'd2) full_push_err++;
    if (reset && !op_flush && ifid_valid && decode_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%h/%h required=none", ifid_instruction, ifid_pc_pre);
      end else begin
        mon_e = exp_q.pop_front();
        if (verbose) $display("pop instruction=%h pc_pre=%h", ifid_instruction, ifid_pc_pre);
        chk("pop_instruction", 32'(ifid_instruction), 32'(mon_e[31:16]));
        chk("pop_pc_pre", 32'(ifid_pc_pre), 32'(mon_e[15:0]));
      end
    end
  end

  initial begin
    bit found;
    int pops_before;

    // Held in reset
    repeat (3) step();
    chk_reset_outputs("reset");

    // Release with decode always ready: one instruction per cycle from address 0
    reset = 1'b1;
    decode_ready = 1'b1;
    load_exp(16'h0000, 200);
    #1;
    chk("release_fetch_enable", 32'(fetch_enable), 32'd1);
    step();
    chk("first_not_yet_valid", 32'(ifid_valid), 32'd0);
    step();
    chk("first_valid", 32'(ifid_valid), 32'd1);
    chk("first_instruction", 32'(ifid_instruction), 32'h1000);
    chk("first_pc_pre", 32'(ifid_pc_pre), 32'd1);

    // Stall decode once address 3 is at the head
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ifid_valid && ifid_instruction == 16'h1003) found = 1'b1;
    end
    chk("head3_reached", 32'(found), 32'd1);
    decode_ready = 1'b0;
    repeat (5) step();
    chk("stall_queue_count", 32'(queue_count), 32'd2);
    chk("stall_fetch_enable", 32'(fetch_enable), 32'd0);
    chk("stall_head", 32'(ifid_instruction), 32'h1003);
    decode_ready = 1'b1;
    repeat (6) step();
    chk("stream_queue_count", 32'(queue_count), 32'd1);

    // Flush to 0x0040 with a full queue
    decode_ready = 1'b0;
    wait_count2("full_before_flush");
    op_flush = 1'b1;
    flush_target = 16'h0040;
    load_exp(16'h0040, 200);
    #1;
    chk("flush_fetch_enable", 32'(fetch_enable), 32'd1);
    step();
    op_flush = 1'b0;
    chk("flush_n1_valid", 32'(ifid_valid), 32'd0);
    chk("flush_n1_count", 32'(queue_count), 32'd0);
    step();
    chk("flush_n2_valid", 32'(ifid_valid), 32'd0);
    step();
    chk("flush_n3_valid", 32'(ifid_valid), 32'd1);
    chk("flush_n3_instruction", 32'(ifid_instruction), 32'h1040);
    chk("flush_n3_pc_pre", 32'(ifid_pc_pre), 32'h0041);
    decode_ready = 1'b1;
    repeat (6) step();

    // Flush together with decode_ready at count 1: flush wins
    chk("pre_flush_ready_count", 32'(queue_count), 32'd1);
    op_flush = 1'b1;
    flush_target = 16'h0080;
    load_exp(16'h0080, 200);
    step();
    op_flush = 1'b0;
    chk("flush_ready_count", 32'(queue_count), 32'd0);
    chk("flush_ready_valid", 32'(ifid_valid), 32'd0);
    repeat (8) step();

    // Reset with a full queue, flush and decode_ready also asserted
    decode_ready = 1'b0;
    wait_count2("full_before_reset");
    reset = 1'b0;
    op_flush = 1'b1;
    decode_ready = 1'b1;
    flush_target = 16'h0055;
    exp_q.delete();
    #1;
    chk("in_reset_fetch_enable", 32'(fetch_enable), 32'd0);
    step();
    chk_reset_outputs("midreset");
    reset = 1'b1;
    op_flush = 1'b0;
    load_exp(16'h0000, 200);
    step();
    step();
    chk("rerelease_valid", 32'(ifid_valid), 32'd1);
    chk("rerelease_instruction", 32'(ifid_instruction), 32'h1000);
    chk("rerelease_pc_pre", 32'(ifid_pc_pre), 32'd1);
    repeat (4) step();

    // Random decode back-pressure from a fresh target
    op_flush = 1'b1;
    flush_target = 16'h0200;
    load_exp(16'h0200, 12000);
    step();
    op_flush = 1'b0;
    verbose = 1'b0;
    pops_before = pops;
    for (int i = 0; i < 10000; i++) begin
      decode_ready = 1'($urandom_range(0, 1));
      step();
    end
    decode_ready = 1'b0;
    step();
    chk("random_progress", 32'((pops - pops_before) > 2000), 32'd1);
    chk("no_push_when_full", 32'(full_push_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
